// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler.
// FSM state, register index type and stall counter width.
package dual_issue_scheduler_pkg;

  localparam int CNT_W = 16;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    PAIR,
    SECOND
  } state_t;

endpackage

// File: rtl/dual_issue_scheduler_hazard_check.sv
// Pairwise hazard between an older producer and a younger consumer.
// Flags a RAW on rd (x0 excluded) or a shared memory-port conflict.
module hazard_check
  import dual_issue_scheduler_pkg::*;
(
  input  logic     p_wr,
  input  reg_idx_t p_rd,
  input  logic     p_mem,
  input  reg_idx_t c_rs1,
  input  reg_idx_t c_rs2,
  input  logic     c_rs2_used,
  input  logic     c_mem,
  output logic     hit
);

  logic rs1_hit;
  logic rs2_hit;
  logic raw;

  assign rs1_hit = p_rd == c_rs1;
  assign rs2_hit = c_rs2_used & (p_rd == c_rs2);
  assign raw     = p_wr & (p_rd != '0) & (rs1_hit | rs2_hit);
  assign hit     = raw | (p_mem & c_mem);

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: co-issues a decoded pair or splits it,
// inserting one bubble on a load-use hazard against the last issued load.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  reg_idx_t         s0_rd,
  input  reg_idx_t         s0_rs1,
  input  reg_idx_t         s0_rs2,
  input  logic             s0_wr,
  input  logic             s0_rs2_used,
  input  logic             s0_load,
  input  logic             s0_store,
  input  logic             s0_ctrl,
  input  reg_idx_t         s1_rd,
  input  reg_idx_t         s1_rs1,
  input  reg_idx_t         s1_rs2,
  input  logic             s1_wr,
  input  logic             s1_rs2_used,
  input  logic             s1_load,
  input  logic             s1_store,
  input  logic             s1_ctrl,
  input  logic             out_ready,
  input  logic             flush,
  output logic             lane0_valid,
  output logic             lane1_valid,
  output logic             lane0_is_slot1,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  state_t   state;
  state_t   state_nxt;
  logic     lu_valid;
  reg_idx_t lu_rd;

  logic     pair_hit;
  logic     lu0_hit;
  logic     lu1_hit;
  logic     co_issue;
  logic     bubble;
  logic     ld_issue;
  reg_idx_t ld_rd;

  // Slot 1 never needs its own wr/ctrl bits: nothing younger is checked.
  logic unused_in;
  assign unused_in = &{1'b0, s1_wr, s1_ctrl};

  hazard_check u_pair (
    .p_wr       (s0_wr),
    .p_rd       (s0_rd),
    .p_mem      (s0_load | s0_store),
    .c_rs1      (s1_rs1),
    .c_rs2      (s1_rs2),
    .c_rs2_used (s1_rs2_used),
    .c_mem      (s1_load | s1_store),
    .hit        (pair_hit)
  );

  hazard_check u_lu0 (
    .p_wr       (lu_valid),
    .p_rd       (lu_rd),
    .p_mem      (1'b0),
    .c_rs1      (s0_rs1),
    .c_rs2      (s0_rs2),
    .c_rs2_used (s0_rs2_used),
    .c_mem      (1'b0),
    .hit        (lu0_hit)
  );

  hazard_check u_lu1 (
    .p_wr       (lu_valid),
    .p_rd       (lu_rd),
    .p_mem      (1'b0),
    .c_rs1      (s1_rs1),
    .c_rs2      (s1_rs2),
    .c_rs2_used (s1_rs2_used),
    .c_mem      (1'b0),
    .hit        (lu1_hit)
  );

  assign co_issue = !s0_ctrl & !pair_hit & !lu1_hit;

  always_comb begin
    lane0_valid    = 1'b0;
    lane1_valid    = 1'b0;
    lane0_is_slot1 = 1'b0;
    in_ready       = 1'b0;
    bubble         = 1'b0;
    state_nxt      = state;
    if (rst) begin
      state_nxt = PAIR;
    end else if (flush) begin
      in_ready  = 1'b1;
      state_nxt = PAIR;
    end else if (out_ready) begin
      unique case (state)
        PAIR: begin
          if (in_valid) begin
            if (lu0_hit) begin
              bubble = 1'b1;
            end else begin
              lane0_valid = 1'b1;
              if (co_issue) begin
                lane1_valid = 1'b1;
                in_ready    = 1'b1;
              end else begin
                state_nxt = SECOND;
              end
            end
          end
        end
        SECOND: begin
          if (lu1_hit) begin
            bubble = 1'b1;
          end else begin
            lane0_valid    = 1'b1;
            lane0_is_slot1 = 1'b1;
            in_ready       = 1'b1;
            state_nxt      = PAIR;
          end
        end
      endcase
    end
  end

  // At most one lane carries a load, so the selects are exclusive.
  always_comb begin
    ld_issue = 1'b0;
    ld_rd    = '0;
    unique case (1'b1)
      lane0_valid & !lane0_is_slot1 & s0_load: begin
        ld_issue = 1'b1;
        ld_rd    = s0_rd;
      end
      (lane1_valid | lane0_is_slot1) & s1_load: begin
        ld_issue = 1'b1;
        ld_rd    = s1_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PAIR;
      lu_valid     <= 1'b0;
      lu_rd        <= '0;
      lu_stall_cnt <= '0;
    end else if (flush) begin
      state    <= PAIR;
      lu_valid <= 1'b0;
    end else if (out_ready) begin
      state    <= state_nxt;
      lu_valid <= ld_issue & (ld_rd != '0);
      if (ld_issue)
        lu_rd <= ld_rd;
      if (bubble && lu_stall_cnt != '1)
        lu_stall_cnt <= lu_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios plus random pairs
// compared against a behavioural issue model.
module tb_dual_issue_scheduler;

  typedef struct {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr;
    logic       rs2u;
    logic       ld;
    logic       st;
    logic       ctrl;
  } slot_s;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        flush;
  logic        lane0_valid;
  logic        lane1_valid;
  logic        lane0_is_slot1;
  logic [15:0] lu_stall_cnt;

  slot_s a;
  slot_s b;

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .s0_rd          (a.rd),
    .s0_rs1         (a.rs1),
    .s0_rs2         (a.rs2),
    .s0_wr          (a.wr),
    .s0_rs2_used    (a.rs2u),
    .s0_load        (a.ld),
    .s0_store       (a.st),
    .s0_ctrl        (a.ctrl),
    .s1_rd          (b.rd),
    .s1_rs1         (b.rs1),
    .s1_rs2         (b.rs2),
    .s1_wr          (b.wr),
    .s1_rs2_used    (b.rs2u),
    .s1_load        (b.ld),
    .s1_store       (b.st),
    .s1_ctrl        (b.ctrl),
    .out_ready      (out_ready),
    .flush          (flush),
    .lane0_valid    (lane0_valid),
    .lane1_valid    (lane1_valid),
    .lane0_is_slot1 (lane0_is_slot1),
    .lu_stall_cnt   (lu_stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: waiting for slot 1, pending load dest (-1 none), stalls.
  bit m_second;
  int m_lu;
  int m_stalls;
  bit n_second;
  int n_lu;
  int n_stalls;
  bit e_l0, e_l1, e_sel, e_inr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  function automatic slot_s mk(int rd, int rs1, int rs2, bit wr,
                               bit rs2u, bit ld, bit st, bit ctrl);
    slot_s s;
    s.rd   = 5'(rd);
    s.rs1  = 5'(rs1);
    s.rs2  = 5'(rs2);
    s.wr   = wr;
    s.rs2u = rs2u;
    s.ld   = ld;
    s.st   = st;
    s.ctrl = ctrl;
    return s;
  endfunction

  function automatic slot_s rnd();
    slot_s s;
    int k;
    k      = int'($urandom_range(0, 5));
    s.rd   = 5'($urandom_range(0, 7));
    s.rs1  = 5'($urandom_range(0, 7));
    s.rs2  = 5'($urandom_range(0, 7));
    s.rs2u = 1'($urandom_range(0, 1));
    s.ld   = k == 0;
    s.st   = k == 1;
    s.ctrl = k == 2;
    s.wr   = s.ld || (k != 1 && $urandom_range(0, 3) != 0);
    return s;
  endfunction

  function automatic bit uses(int r, slot_s s);
    if (r < 0) return 1'b0;
    return int'(s.rs1) == r || (s.rs2u && int'(s.rs2) == r);
  endfunction

  task automatic model_eval();
    int dest;
    bit stall;
    bit dep;
    bit mem;
    dest  = 0;
    stall = 0;
    if (rst) begin
      m_second = 0;
      m_lu     = -1;
      m_stalls = 0;
    end
    e_l0 = 0; e_l1 = 0; e_sel = 0; e_inr = 0;
    n_second = m_second;
    n_lu     = m_lu;
    n_stalls = m_stalls;
    if (rst) begin
      n_second = 0;
    end else if (flush) begin
      e_inr    = 1;
      n_second = 0;
      n_lu     = -1;
    end else if (out_ready) begin
      if (!m_second) begin
        if (in_valid) begin
          if (uses(m_lu, a)) begin
            stall = 1;
          end else begin
            dep  = a.wr && a.rd != 0 && uses(int'(a.rd), b);
            mem  = (a.ld || a.st) && (b.ld || b.st);
            e_l0 = 1;
            if (a.ld) dest = int'(a.rd);
            if (!a.ctrl && !mem && !dep && !uses(m_lu, b)) begin
              e_l1  = 1;
              e_inr = 1;
              if (b.ld) dest = int'(b.rd);
            end else begin
              n_second = 1;
            end
          end
        end
      end else if (uses(m_lu, b)) begin
        stall = 1;
      end else begin
        e_l0 = 1; e_sel = 1; e_inr = 1;
        n_second = 0;
        if (b.ld) dest = int'(b.rd);
      end
      n_lu = dest != 0 ? dest : -1;
      if (stall && n_stalls < 65535) n_stalls++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_eval();
    chk("lane0_valid", 32'(lane0_valid), 32'(e_l0));
    chk("lane1_valid", 32'(lane1_valid), 32'(e_l1));
    chk("lane0_is_slot1", 32'(lane0_is_slot1), 32'(e_sel));
    chk("in_ready", 32'(in_ready), 32'(e_inr));
    chk("lu_stall_cnt", 32'(lu_stall_cnt), 32'(m_stalls));
    @(posedge clk);
    m_second = n_second;
    m_lu     = n_lu;
    m_stalls = n_stalls;
    #1;
  endtask

  task automatic pre(input string tag, input bit l0, input bit l1,
                     input bit sel, input bit inr);
    #1;
    chk({tag, "_l0"}, 32'(lane0_valid), 32'(l0));
    chk({tag, "_l1"}, 32'(lane1_valid), 32'(l1));
    chk({tag, "_sel"}, 32'(lane0_is_slot1), 32'(sel));
    chk({tag, "_inr"}, 32'(in_ready), 32'(inr));
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; flush = 0;
    a = mk(0, 0, 0, 0, 0, 0, 0, 0);
    b = a;
    m_second = 0; m_lu = -1; m_stalls = 0;
    cyc();
    cyc();
    chk("reset_cnt", 32'(lu_stall_cnt), 32'd0);
    pre("reset", 0, 0, 0, 0);
    rst = 0;
    cyc();

    in_valid = 1;
    a = mk(5, 1, 2, 1, 0, 0, 0, 0);
    b = mk(8, 6, 7, 1, 1, 0, 0, 0);
    pre("indep", 1, 1, 0, 1);
    cyc();

    a = mk(5, 1, 2, 1, 0, 0, 0, 0);
    b = mk(9, 5, 0, 1, 0, 0, 0, 0);
    pre("raw_c1", 1, 0, 0, 0);
    cyc();
    pre("raw_c2", 1, 0, 1, 1);
    cyc();

    a = mk(3, 1, 2, 1, 0, 1, 0, 0);
    b = mk(4, 1, 2, 1, 0, 0, 0, 0);
    pre("load", 1, 1, 0, 1);
    cyc();
    a = mk(6, 3, 0, 1, 0, 0, 0, 0);
    b = mk(7, 1, 0, 1, 0, 0, 0, 0);
    pre("lu_bubble", 0, 0, 0, 0);
    chk("lu_cnt_before", 32'(lu_stall_cnt), 32'd0);
    cyc();
    chk("lu_cnt_after", 32'(lu_stall_cnt), 32'd1);
    pre("lu_issue", 1, 1, 0, 1);
    cyc();

    a = mk(9, 1, 0, 1, 0, 1, 0, 0);
    b = mk(0, 2, 3, 0, 1, 0, 1, 0);
    pre("ldst_c1", 1, 0, 0, 0);
    cyc();
    pre("ldst_c2", 1, 0, 1, 1);
    cyc();

    a = mk(1, 2, 0, 1, 0, 0, 0, 1);
    b = mk(4, 5, 0, 1, 0, 0, 0, 0);
    pre("br_c1", 1, 0, 0, 0);
    cyc();
    flush = 1;
    pre("flush", 0, 0, 0, 1);
    cyc();
    flush = 0;
    a = mk(10, 11, 0, 1, 0, 0, 0, 0);
    b = mk(12, 13, 0, 1, 0, 0, 0, 0);
    pre("post_flush", 1, 1, 0, 1);
    cyc();

    a = mk(1, 2, 0, 1, 0, 0, 0, 1);
    b = mk(4, 5, 0, 1, 0, 0, 0, 0);
    cyc();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      pre("hold", 0, 0, 0, 0);
      cyc();
    end
    out_ready = 1;
    pre("release", 1, 0, 1, 1);
    cyc();

    cyc();
    rst = 1;
    pre("rst_mid", 0, 0, 0, 0);
    chk("rst_mid_cnt", 32'(lu_stall_cnt), 32'd0);
    cyc();
    rst = 0;
    in_valid = 0;
    pre("idle", 0, 0, 0, 0);
    cyc();
    in_valid = 1;
    pre("after_rst", 1, 0, 0, 0);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !e_inr)) begin
        in_valid = $urandom_range(0, 4) != 0;
        a = rnd();
        b = rnd();
      end
      out_ready = $urandom_range(0, 4) != 0;
      flush     = $urandom_range(0, 24) == 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
